// File: rtl/order_pkg.sv
// Shared order-frame definitions: byte offsets, char codes, field bundle.
// Used by the serializer and the matching order-book parser.
package order_pkg;

  localparam int MSG_BYTES = 40;
  localparam int MSG_BITS  = MSG_BYTES * 8;

  // Byte offsets inside the frame (byte 0 = MSB byte).
  localparam int OFF_REQ   = 0;
  localparam int OFF_OID   = 1;
  localparam int OFF_SID   = 5;
  localparam int OFF_QTY   = 9;
  localparam int OFF_PRICE = 13;
  localparam int OFF_SIDE  = 21;
  localparam int OFF_SEQ   = 22;
  localparam int OFF_CSUM  = 39;

  localparam logic [7:0] REQ_ADD   = 8'h41;
  localparam logic [7:0] REQ_DEL   = 8'h44;
  localparam logic [7:0] SIDE_BUY  = 8'h42;
  localparam logic [7:0] SIDE_SELL = 8'h53;

  typedef struct packed {
    logic [7:0]  req_type;
    logic [31:0] order_id;
    logic [31:0] stock_id;
    logic [31:0] quantity;
    logic [63:0] price;
    logic [7:0]  side;
  } order_fields_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } ser_state_t;

endpackage

// File: rtl/order_frame_pack.sv
// Combinational packer: order fields + sequence number -> 320-bit frame.
// Ports: fields_i, seq_i in; frame_o out. Optional ORDER_MSG_CHECKSUM_EN fills byte 39.
module order_frame_pack
  import order_pkg::*;
#(
  parameter int SEQ_W = 16
) (
  input  order_fields_t        fields_i,
  input  logic [SEQ_W-1:0]     seq_i,
  output logic [MSG_BITS-1:0]  frame_o
);

  logic [7:0]  b [MSG_BYTES];
  logic [15:0] seq16;
  logic [7:0]  csum;

  // Only the low 16 bits of the sequence fit in the frame.
  assign seq16 = 16'(seq_i);

  always_comb begin
    for (int i = 0; i < MSG_BYTES; i++) b[i] = 8'h00;
    b[OFF_REQ] = fields_i.req_type;
    for (int i = 0; i < 4; i++) begin
      b[OFF_OID+i] = fields_i.order_id[8*i +: 8];
      b[OFF_SID+i] = fields_i.stock_id[8*i +: 8];
      b[OFF_QTY+i] = fields_i.quantity[8*i +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      b[OFF_PRICE+i] = fields_i.price[8*i +: 8];
    end
    b[OFF_SIDE]  = fields_i.side;
    b[OFF_SEQ]   = seq16[7:0];
    b[OFF_SEQ+1] = seq16[15:8];
    csum = 8'h00;
`ifdef ORDER_MSG_CHECKSUM_EN
    for (int i = 0; i < OFF_CSUM; i++) csum = csum ^ b[i];
`endif
    b[OFF_CSUM] = csum;
    frame_o = '0;
    for (int i = 0; i < MSG_BYTES; i++) begin
      frame_o[MSG_BITS-1-8*i -: 8] = b[i];
    end
  end

endmodule

// File: rtl/order_msg_serializer.sv
// Packs one order into a 40-byte frame and streams it MSB-byte-first in DATA_W beats.
// Ports: clk, reset(sync, high); in_valid/in_ready + order fields in;
//  out_data/out_valid/out_last/out_ready stream; frame_count.
// Define ORDER_MSG_CHECKSUM_EN to place an XOR checksum in byte 39.
module order_msg_serializer
  import order_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEQ_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        req_type,
  input  logic [31:0]       order_id,
  input  logic [31:0]       stock_id,
  input  logic [31:0]       quantity,
  input  logic [63:0]       price,
  input  logic [7:0]        side,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [SEQ_W-1:0]  frame_count
);

  localparam int BEATS = MSG_BITS / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic ONE_BEAT = (BEATS == 1);

  ser_state_t          state_q;
  logic [MSG_BITS-1:0] shift_q;
  logic                valid_q;
  logic                last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [SEQ_W-1:0]    seq_q;
  logic [SEQ_W-1:0]    fcnt_q;
  order_fields_t       fields;
  logic [MSG_BITS-1:0] frame;

  assign fields = '{
    req_type: req_type,
    order_id: order_id,
    stock_id: stock_id,
    quantity: quantity,
    price:    price,
    side:     side
  };

  order_frame_pack #(
    .SEQ_W (SEQ_W)
  ) u_pack (
    .fields_i (fields),
    .seq_i    (seq_q),
    .frame_o  (frame)
  );

  // Ready in IDLE, or on the last beat handshake so frames run with no bubble.
  assign in_ready = !reset &&
    ((state_q == ST_IDLE) ||
     (state_q == ST_SEND && valid_q && out_ready && last_q));

  assign cnt_d = cnt_q + 1'b1;

  assign out_data    = shift_q[MSG_BITS-1 -: DATA_W];
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign frame_count = fcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      seq_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= ST_SEND;
            shift_q <= frame;
            seq_q   <= seq_q + 1'b1;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= ONE_BEAT;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (last_q) begin
              fcnt_q <= fcnt_q + 1'b1;
              if (in_valid) begin
                shift_q <= frame;
                seq_q   <= seq_q + 1'b1;
                cnt_q   <= '0;
                last_q  <= ONE_BEAT;
              end else begin
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
              end
            end else begin
              shift_q <= shift_q << DATA_W;
              cnt_q   <= cnt_d;
              last_q  <= (cnt_d == LAST_CNT);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_order_msg_serializer.sv
// Directed bench for order_msg_serializer: 8-bit and 64-bit beat instances.
// Honors ORDER_MSG_CHECKSUM_EN for the expected byte 39.
module tb_order_msg_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  req_type, side;
  logic [31:0] order_id, stock_id, quantity;
  logic [63:0] price;

  logic        in_valid8, in_ready8;
  logic [7:0]  out_data8;
  logic        out_valid8, out_last8, out_ready8;
  logic [15:0] fc8;

  logic        in_valid64, in_ready64;
  logic [63:0] out_data64;
  logic        out_valid64, out_last64, out_ready64;
  logic [3:0]  fc64;

  int pass_n = 0;
  int total_n = 0;

  logic [7:0] rx [$];
  int gaps, stall_err, last_err, acc_cyc, first_cyc;

  order_msg_serializer #(.DATA_W(8), .SEQ_W(16)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .req_type(req_type), .order_id(order_id), .stock_id(stock_id),
    .quantity(quantity), .price(price), .side(side),
    .out_data(out_data8), .out_valid(out_valid8), .out_last(out_last8),
    .out_ready(out_ready8), .frame_count(fc8)
  );

  order_msg_serializer #(.DATA_W(64), .SEQ_W(4)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .req_type(req_type), .order_id(order_id), .stock_id(stock_id),
    .quantity(quantity), .price(price), .side(side),
    .out_data(out_data64), .out_valid(out_valid64), .out_last(out_last64),
    .out_ready(out_ready64), .frame_count(fc64)
  );

  function automatic logic [31:0] bs32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [63:0] bs64(input logic [63:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24],
            x[39:32], x[47:40], x[55:48], x[63:56]};
  endfunction

  function automatic logic [319:0] build_frame(
    input logic [7:0] rq, input logic [31:0] oid, input logic [31:0] sid,
    input logic [31:0] qty, input logic [63:0] pr, input logic [7:0] sd,
    input logic [15:0] sq);
    logic [319:0] f;
    logic [7:0] c;
    f = {rq, bs32(oid), bs32(sid), bs32(qty), bs64(pr), sd,
         sq[7:0], sq[15:8], 120'h0, 8'h00};
    c = 8'h00;
`ifdef ORDER_MSG_CHECKSUM_EN
    for (int i = 0; i < 39; i++) c = c ^ f[319-8*i -: 8];
`endif
    f[7:0] = c;
    return f;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [7:0] rq, input logic [31:0] oid,
    input logic [31:0] sid, input logic [31:0] qty, input logic [63:0] pr,
    input logic [7:0] sd);
    req_type = rq; order_id = oid; stock_id = sid;
    quantity = qty; price = pr; side = sd;
  endtask

  // Raises in_valid8 until naccept frames are taken; gathers nbeats bytes.
  task automatic collect8(input int nbeats, input int naccept, input bit rnd);
    bit seen, held, drop;
    logic [7:0] pd;
    logic pl;
    int cyc, left;
    rx.delete();
    gaps = 0; stall_err = 0; last_err = 0;
    acc_cyc = -1; first_cyc = -1;
    seen = 0; held = 0; cyc = 0; left = naccept;
    pd = 8'h00; pl = 1'b0;
    in_valid8 = 1'b1;
    while (rx.size() < nbeats && cyc < 3000) begin
      out_ready8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      drop = 0;
      if (held && (!out_valid8 || out_data8 !== pd || out_last8 !== pl))
        stall_err++;
      if (seen && !out_valid8) gaps++;
      if (out_valid8 && !seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (in_valid8 && in_ready8) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        left--;
        if (left == 0) drop = 1;
      end
      held = 0;
      if (out_valid8 && out_ready8) begin
        rx.push_back(out_data8);
        if (out_last8 !== ((rx.size() % 40) == 0)) last_err++;
      end else if (out_valid8) begin
        held = 1;
        pd = out_data8;
        pl = out_last8;
      end
      step();
      cyc++;
      if (drop) in_valid8 = 1'b0;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    in_valid64 = 1'b0; out_ready64 = 1'b1;
    set_fields(8'h0, 32'h0, 32'h0, 32'h0, 64'h0, 8'h0);
    repeat (3) step();
    total_n++;
    if (in_ready8 !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready8);
    else pass_n++;
    total_n++;
    if (out_valid8 !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid8);
    else pass_n++;
    total_n++;
    if (out_last8 !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last8);
    else pass_n++;
    total_n++;
    if (out_data8 !== 8'h00) $display("FAIL rst_out_data: got %h want 00", out_data8);
    else pass_n++;
    total_n++;
    if (fc8 !== 16'd0) $display("FAIL rst_frame_count: got %0d want 0", fc8);
    else pass_n++;
    reset = 1'b0;
    #1;
    total_n++;
    if (in_ready8 !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready8);
    else pass_n++;
    step();
  endtask

  task automatic test_single;
    logic [319:0] exp_f;
    logic [7:0] e, xr;
    logic [7:0] ck;
`ifdef ORDER_MSG_CHECKSUM_EN
    ck = 8'hC9;
`else
    ck = 8'h00;
`endif
    exp_f = {8'h41, 32'h78563412, 32'hEA080000, 32'h64000000,
             64'h5500000000000000, 8'h53, 16'h0000, 120'h0, ck};
    set_fields(8'h41, 32'h12345678, 32'h000008EA, 32'h64, 64'h55, 8'h53);
    collect8(40, 1, 0);
    total_n++;
    if (rx.size() !== 40) $display("FAIL single_beats: got %0d want 40", rx.size());
    else pass_n++;
    total_n++;
    if (first_cyc - acc_cyc !== 1)
      $display("FAIL single_latency: got %0d want 1", first_cyc - acc_cyc);
    else pass_n++;
    total_n++;
    if (last_err !== 0) $display("FAIL single_last: got %0d errs want 0", last_err);
    else pass_n++;
    for (int i = 0; i < 40 && i < rx.size(); i++) begin
      e = exp_f[319-8*i -: 8];
      total_n++;
      if (rx[i] !== e) $display("FAIL single_byte%0d: got %h want %h", i, rx[i], e);
      else pass_n++;
    end
    if (rx.size() == 40) begin
      total_n++;
      if ({rx[4], rx[3], rx[2], rx[1]} !== 32'h12345678)
        $display("FAIL parse_order_id: got %h want 12345678", {rx[4], rx[3], rx[2], rx[1]});
      else pass_n++;
      total_n++;
      if ({rx[8], rx[7], rx[6], rx[5]} !== 32'h000008EA)
        $display("FAIL parse_stock_id: got %h want 000008ea", {rx[8], rx[7], rx[6], rx[5]});
      else pass_n++;
      total_n++;
      if ({rx[12], rx[11], rx[10], rx[9]} !== 32'h64)
        $display("FAIL parse_qty: got %h want 64", {rx[12], rx[11], rx[10], rx[9]});
      else pass_n++;
      total_n++;
      if ({rx[20], rx[19], rx[18], rx[17], rx[16], rx[15], rx[14], rx[13]} !== 64'h55)
        $display("FAIL parse_price: got byte13 %h want 55", rx[13]);
      else pass_n++;
      total_n++;
      if (rx[0] !== 8'h41 || rx[21] !== 8'h53)
        $display("FAIL parse_req_side: got %h %h want 41 53", rx[0], rx[21]);
      else pass_n++;
      xr = 8'h00;
      for (int i = 0; i < 39; i++) xr = xr ^ rx[i];
`ifndef ORDER_MSG_CHECKSUM_EN
      xr = 8'h00;
`endif
      total_n++;
      if (rx[39] !== xr) $display("FAIL checksum_b39: got %h want %h", rx[39], xr);
      else pass_n++;
    end
    total_n++;
    if (fc8 !== 16'd1) $display("FAIL single_frame_count: got %0d want 1", fc8);
    else pass_n++;
  endtask

  task automatic test_back_to_back;
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_fields(8'h41, 32'h12345678, 32'h000008EA, 32'h64, 64'h55, 8'h53);
    collect8(80, 2, 0);
    total_n++;
    if (rx.size() !== 80) $display("FAIL b2b_beats: got %0d want 80", rx.size());
    else pass_n++;
    total_n++;
    if (gaps !== 0) $display("FAIL b2b_gap: got %0d idle cycles want 0", gaps);
    else pass_n++;
    total_n++;
    if (last_err !== 0) $display("FAIL b2b_last: got %0d errs want 0", last_err);
    else pass_n++;
    if (rx.size() == 80) begin
      total_n++;
      if ({rx[22], rx[23]} !== 16'h0000)
        $display("FAIL b2b_seq0: got %h %h want 00 00", rx[22], rx[23]);
      else pass_n++;
      total_n++;
      if ({rx[62], rx[63]} !== 16'h0100)
        $display("FAIL b2b_seq1: got %h %h want 01 00", rx[62], rx[63]);
      else pass_n++;
    end
    total_n++;
    if (fc8 !== 16'd2) $display("FAIL b2b_frame_count: got %0d want 2", fc8);
    else pass_n++;
  endtask

  task automatic test_random_ready;
    logic [319:0] g0, g1;
    int bad;
    set_fields(8'h44, 32'hDEADBEEF, 32'h00000001, 32'h0, 64'h0123456789ABCDEF, 8'h42);
    g0 = build_frame(8'h44, 32'hDEADBEEF, 32'h1, 32'h0, 64'h0123456789ABCDEF, 8'h42, 16'd2);
    g1 = build_frame(8'h44, 32'hDEADBEEF, 32'h1, 32'h0, 64'h0123456789ABCDEF, 8'h42, 16'd3);
    collect8(80, 2, 1);
    total_n++;
    if (stall_err !== 0) $display("FAIL rnd_stall_stable: got %0d errs want 0", stall_err);
    else pass_n++;
    total_n++;
    if (last_err !== 0) $display("FAIL rnd_last: got %0d errs want 0", last_err);
    else pass_n++;
    bad = 0;
    for (int i = 0; i < rx.size(); i++) begin
      if (i < 40) begin
        if (rx[i] !== g0[319-8*i -: 8]) bad++;
      end else begin
        if (rx[i] !== g1[319-8*(i-40) -: 8]) bad++;
      end
    end
    total_n++;
    if (bad !== 0 || rx.size() !== 80)
      $display("FAIL rnd_stream: got %0d bad of %0d want 0 of 80", bad, rx.size());
    else pass_n++;
    total_n++;
    if (fc8 !== 16'd4) $display("FAIL rnd_frame_count: got %0d want 4", fc8);
    else pass_n++;
  endtask

  task automatic test_reset_midframe;
    logic [319:0] g;
    int bad;
    set_fields(8'h41, 32'h12345678, 32'h000008EA, 32'h64, 64'h55, 8'h53);
    out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    repeat (10) step();
    total_n++;
    if (out_valid8 !== 1'b1) $display("FAIL mid_active: got %b want 1", out_valid8);
    else pass_n++;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    total_n++;
    if (out_valid8 !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid8);
    else pass_n++;
    total_n++;
    if (fc8 !== 16'd0) $display("FAIL mid_rst_count: got %0d want 0", fc8);
    else pass_n++;
    g = build_frame(8'h41, 32'h12345678, 32'h000008EA, 32'h64, 64'h55, 8'h53, 16'd0);
    collect8(40, 1, 0);
    bad = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== g[319-8*i -: 8]) bad++;
    total_n++;
    if (bad !== 0 || rx.size() !== 40)
      $display("FAIL mid_restart_frame: got %0d bad of %0d want 0 of 40", bad, rx.size());
    else pass_n++;
    total_n++;
    if (fc8 !== 16'd1) $display("FAIL mid_restart_count: got %0d want 1", fc8);
    else pass_n++;
  endtask

  task automatic test_wide;
    logic [63:0] rx64 [$];
    logic [319:0] g;
    logic [3:0] fc_at16;
    bit drop, snap;
    int left, cyc, lerr, bad;
    set_fields(8'h41, 32'h12345678, 32'h000008EA, 32'h64, 64'h55, 8'h53);
    out_ready64 = 1'b1;
    in_valid64 = 1'b1;
    left = 17; cyc = 0; lerr = 0; snap = 0; fc_at16 = 4'hF;
    while (rx64.size() < 85 && cyc < 1000) begin
      #1;
      drop = 0;
      if (in_valid64 && in_ready64) begin
        left--;
        if (left == 0) drop = 1;
      end
      if (out_valid64 && out_ready64) begin
        rx64.push_back(out_data64);
        if (out_last64 !== ((rx64.size() % 5) == 0)) lerr++;
        if (rx64.size() == 80) snap = 1;
      end
      step();
      cyc++;
      if (drop) in_valid64 = 1'b0;
      if (snap) begin
        fc_at16 = fc64;
        snap = 0;
      end
    end
    in_valid64 = 1'b0;
    total_n++;
    if (rx64.size() !== 85) $display("FAIL wide_beats: got %0d want 85", rx64.size());
    else pass_n++;
    total_n++;
    if (lerr !== 0) $display("FAIL wide_last: got %0d errs want 0", lerr);
    else pass_n++;
    if (rx64.size() == 85) begin
      total_n++;
      if (rx64[0] !== 64'h4178563412EA0800)
        $display("FAIL wide_beat0: got %h want 4178563412ea0800", rx64[0]);
      else pass_n++;
      bad = 0;
      for (int f = 0; f < 17; f++) begin
        g = build_frame(8'h41, 32'h12345678, 32'h000008EA, 32'h64, 64'h55,
                        8'h53, 16'(f % 16));
        for (int b = 0; b < 5; b++)
          if (rx64[f*5+b] !== g[319-64*b -: 64]) bad++;
      end
      total_n++;
      if (bad !== 0) $display("FAIL wide_stream: got %0d bad beats want 0", bad);
      else pass_n++;
      total_n++;
      if (rx64[82][15:8] !== 8'h00)
        $display("FAIL wide_seq_wrap: got %h want 00", rx64[82][15:8]);
      else pass_n++;
    end
    total_n++;
    if (fc_at16 !== 4'd0) $display("FAIL wide_fc_wrap: got %0d want 0", fc_at16);
    else pass_n++;
    total_n++;
    if (fc64 !== 4'd1) $display("FAIL wide_fc_final: got %0d want 1", fc64);
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random_ready();
    test_reset_midframe();
    test_wide();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
